// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard and forwarding controller for the 5-stage RV32 pipeline. It sits
// beside pipeline registers 1/2 and its outputs gate the PC, IF/ID and ID/EX
// loads.
//
// A DEPTH-entry scoreboard follows every in-flight instruction:
//   entry0 = EX, entry1 = MEM, entry2 = WB, entry3 = post-WB, and so on.
// The post-WB entry covers the same-cycle regfile read/write race.
// Only entry0 keeps the source fields (rs1/rs2/used flags), because only the
// instruction in EX needs operand forward selects.
//
// Parameters:
//   REG_AW  register address width (default 5)
//   DEPTH   scoreboard entries, legal 3..8 (default 4)
//   SEL_W   forward-select width, $clog2(DEPTH) (localparam)
//
// Ports:
//   CLK           in   clock; all state changes on the rising edge
//   RESET         in   synchronous, active-low; while low all outputs are 0
//   id_valid      in   IF/ID holds a real instruction
//   id_rs1/rs2    in   ID source registers
//   id_rs1_used   in   ID instruction reads rs1
//   id_rs2_used   in   ID instruction reads rs2
//   id_rd         in   ID destination register
//   id_reg_write  in   ID instruction writes rd
//   id_mem_read   in   ID instruction is a load
//   ex_redirect   in   EX resolved a taken branch/jump
//   mem_busywait  in   cache busy; the whole pipe is frozen
//   hold_pc       out  PC must not update
//   hold_ifid     out  IF/ID must not load
//   flush_ifid    out  IF/ID loads a bubble
//   bubble_idex   out  ID/EX loads a bubble
//   freeze        out  mem_busywait, gated by reset
//   fwd_a/fwd_b   out  EX operand source: 0 = pipe reg, k = result of entry k
//   stall_cnt     out  load-use stall cycles (only with HAZ_PERF_CNT_EN)
//   flush_cnt     out  redirect flushes (only with HAZ_PERF_CNT_EN)
//
// Build option:
//   HAZ_PERF_CNT_EN  when defined, adds the two saturating 32-bit counters.
//                    When undefined, stall_cnt/flush_cnt are tied to 0 and
//                    no counter flops exist.
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4,
    localparam int SEL_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_redirect,
    input  logic              mem_busywait,
    output logic              hold_pc,
    output logic              hold_ifid,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic              freeze,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    // Scoreboard entries
    logic              r_v  [DEPTH];
    logic [REG_AW-1:0] r_rd [DEPTH];
    logic              r_we [DEPTH];
    logic              r_ld [DEPTH];
    // Source fields of the instruction in EX (entry0 only)
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_u1;
    logic              r_ex_u2;

    logic              w_wr0_rs1;
    logic              w_wr0_rs2;
    logic              w_load_use;
    logic              w_hold;
    logic              w_flush;
    logic              w_bubble;
    logic [SEL_W-1:0]  w_fwd_a;
    logic [SEL_W-1:0]  w_fwd_b;

    // The instruction in EX writes a source of the instruction in ID (x0 never counts)
    assign w_wr0_rs1 = r_v[0] & r_we[0] & (r_rd[0] == id_rs1) & (id_rs1 != '0);
    assign w_wr0_rs2 = r_v[0] & r_we[0] & (r_rd[0] == id_rs2) & (id_rs2 != '0);

    assign w_load_use = id_valid & r_ld[0] &
                        ((id_rs1_used & w_wr0_rs1) | (id_rs2_used & w_wr0_rs2));

    // Freeze beats redirect beats load-use. A redirect raised while frozen is
    // not lost: the branch stays in EX and acts on the first unfrozen cycle.
    always_comb begin
        w_hold   = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        if (mem_busywait) begin
            w_hold = 1'b1;
        end else if (ex_redirect) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if (w_load_use) begin
            w_hold   = 1'b1;
            w_bubble = 1'b1;
        end
    end

    // Forward selects come only from registered state, so they are stable for
    // the whole cycle and across a freeze. Scanning from the oldest entry down
    // lets the youngest matching producer win. A load in MEM is excluded: its
    // data is not ready yet, and the load-use stall always leaves a gap.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (r_v[k] && r_we[k] && !(k == 1 && r_ld[k])) begin
                if (r_v[0] && r_ex_u1 && (r_ex_rs1 != '0) && (r_rd[k] == r_ex_rs1))
                    w_fwd_a = SEL_W'(k);
                if (r_v[0] && r_ex_u2 && (r_ex_rs2 != '0) && (r_rd[k] == r_ex_rs2))
                    w_fwd_b = SEL_W'(k);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_v[k]  <= 1'b0;
                r_rd[k] <= '0;
                r_we[k] <= 1'b0;
                r_ld[k] <= 1'b0;
            end
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
            r_ex_u1  <= 1'b0;
            r_ex_u2  <= 1'b0;
        end else if (!mem_busywait) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
                r_we[k] <= r_we[k-1];
                r_ld[k] <= r_ld[k-1];
            end
            if (w_bubble) begin
                r_v[0]   <= 1'b0;
                r_rd[0]  <= '0;
                r_we[0]  <= 1'b0;
                r_ld[0]  <= 1'b0;
                r_ex_rs1 <= '0;
                r_ex_rs2 <= '0;
                r_ex_u1  <= 1'b0;
                r_ex_u2  <= 1'b0;
            end else begin
                r_v[0]   <= id_valid;
                r_rd[0]  <= id_rd;
                r_we[0]  <= id_reg_write;
                r_ld[0]  <= id_mem_read;
                r_ex_rs1 <= id_rs1;
                r_ex_rs2 <= id_rs2;
                r_ex_u1  <= id_rs1_used;
                r_ex_u2  <= id_rs2_used;
            end
        end
    end

    assign hold_pc     = RESET & w_hold;
    assign hold_ifid   = RESET & w_hold;
    assign flush_ifid  = RESET & w_flush;
    assign bubble_idex = RESET & w_bubble;
    assign freeze      = RESET & mem_busywait;
    assign fwd_a       = RESET ? w_fwd_a : '0;
    assign fwd_b       = RESET ? w_fwd_b : '0;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // A load-use cycle overridden by a redirect is a flush, not a stall.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busywait) begin
            if (w_load_use && !ex_redirect && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (ex_redirect && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = RESET ? r_stall_cnt : '0;
    assign flush_cnt = RESET ? r_flush_cnt : '0;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int REG_AW = 5;
  localparam int DEPTH  = 4;
  localparam int SEL_W  = 2;

`ifdef HAZ_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_redirect;
  logic              mem_busywait;
  logic              hold_pc;
  logic              hold_ifid;
  logic              flush_ifid;
  logic              bubble_idex;
  logic              freeze;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // {hold_pc, hold_ifid, flush_ifid, bubble_idex, freeze}
  logic [4:0] ctrl;
  logic [3:0] fwd;
  assign ctrl = {hold_pc, hold_ifid, flush_ifid, bubble_idex, freeze};
  assign fwd  = {fwd_a, fwd_b};

  pipe_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_busywait (mem_busywait),
    .hold_pc      (hold_pc),
    .hold_ifid    (hold_ifid),
    .flush_ifid   (flush_ifid),
    .bubble_idex  (bubble_idex),
    .freeze       (freeze),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = we;
    id_mem_read  = ld;
  endtask

  task automatic idle_id();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle_id();
    ex_redirect  = 1'b0;
    mem_busywait = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom_range(1)), 5'($urandom_range(31)), 1'($urandom_range(1)),
             5'($urandom_range(31)), 1'($urandom_range(1)), 5'($urandom_range(31)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
      ex_redirect  = 1'($urandom_range(1));
      mem_busywait = 1'($urandom_range(1));
      settle();
      n_checks++;
      if (ctrl !== 5'b00000) $display("FAIL reset_ctrl: got %b expected %b", ctrl, 5'b00000);
      else n_pass++;
      n_checks++;
      if (fwd !== 4'b0000) $display("FAIL reset_fwd: got %b expected %b", fwd, 4'b0000);
      else n_pass++;
      n_checks++;
      if ({stall_cnt, flush_cnt} !== 64'd0)
        $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      else n_pass++;
      tick();
    end
    idle_id();
    ex_redirect  = 1'b0;
    mem_busywait = 1'b0;
    tick();
    RESET = 1'b1;
    settle();
    n_checks++;
    if (ctrl !== 5'b00000) $display("FAIL post_reset_ctrl: got %b expected %b", ctrl, 5'b00000);
    else n_pass++;
    tick();
    n_checks++;
    if (fwd !== 4'b0000) $display("FAIL post_reset_fwd: got %b expected %b", fwd, 4'b0000);
    else n_pass++;
  endtask

  task automatic test_forward();
    drain();
    // add x5,x1,x2
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    settle();
    n_checks++;
    if (ctrl !== 5'b00000) $display("FAIL fwd_add_ctrl: got %b expected %b", ctrl, 5'b00000);
    else n_pass++;
    tick();
    // sub x6,x5,x3
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
    tick();
    // and x8,x4,x5 in ID; sub in EX, add in MEM
    set_id(1, 5'd4, 1, 5'd5, 1, 5'd8, 1, 0);
    settle();
    n_checks++;
    if (fwd !== {2'd1, 2'd0}) $display("FAIL fwd_mem: got %b expected %b", fwd, {2'd1, 2'd0});
    else n_pass++;
    tick();
    // add x6,x5,x6 in ID; and in EX, add x5 now in WB
    set_id(1, 5'd5, 1, 5'd6, 1, 5'd6, 1, 0);
    settle();
    n_checks++;
    if (fwd !== {2'd0, 2'd2}) $display("FAIL fwd_wb: got %b expected %b", fwd, {2'd0, 2'd2});
    else n_pass++;
    tick();
    // xor x11,x6,x0; add x6,x5,x6 in EX: x5 from post-WB, x6 from WB
    set_id(1, 5'd6, 1, 5'd0, 1, 5'd11, 1, 0);
    settle();
    n_checks++;
    if (fwd !== {2'd3, 2'd2}) $display("FAIL fwd_postwb: got %b expected %b", fwd, {2'd3, 2'd2});
    else n_pass++;
    tick();
    // xor in EX: x6 written by entry1 and entry3, youngest wins; x0 never forwards
    idle_id();
    settle();
    n_checks++;
    if (fwd !== {2'd1, 2'd0}) $display("FAIL fwd_youngest: got %b expected %b", fwd, {2'd1, 2'd0});
    else n_pass++;
  endtask

  task automatic test_load_use();
    drain();
    // lw x6,0(x1)
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
    tick();
    // add x7,x6,x1
    set_id(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0);
    settle();
    n_checks++;
    if (ctrl !== 5'b11010) $display("FAIL lu_stall: got %b expected %b", ctrl, 5'b11010);
    else n_pass++;
    tick();
    settle();
    n_checks++;
    if (ctrl !== 5'b00000) $display("FAIL lu_one_cycle: got %b expected %b", ctrl, 5'b00000);
    else n_pass++;
    tick();
    idle_id();
    settle();
    n_checks++;
    if (fwd !== {2'd2, 2'd0}) $display("FAIL lu_fwd: got %b expected %b", fwd, {2'd2, 2'd0});
    else n_pass++;
    n_checks++;
    if (stall_cnt !== (CNT_EN ? 32'd1 : 32'd0))
      $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, (CNT_EN ? 1 : 0));
    else n_pass++;
  endtask

  task automatic test_redirect();
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
    tick();
    set_id(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0);
    ex_redirect = 1'b1;
    settle();
    n_checks++;
    if (ctrl !== 5'b00110) $display("FAIL redir_override: got %b expected %b", ctrl, 5'b00110);
    else n_pass++;
    tick();
    ex_redirect = 1'b0;
    idle_id();
    settle();
    n_checks++;
    if ({stall_cnt, flush_cnt} !== (CNT_EN ? {32'd1, 32'd1} : 64'd0))
      $display("FAIL redir_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt,
               (CNT_EN ? 1 : 0), (CNT_EN ? 1 : 0));
    else n_pass++;
  endtask

  task automatic test_freeze();
    drain();
    // add x1,x2,x3
    set_id(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);
    tick();
    // lw x6,0(x1)
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
    tick();
    // add x7,x6,x1 behind the load while the cache is busy
    set_id(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0);
    mem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (ctrl !== 5'b11001) $display("FAIL frz_ctrl_%0d: got %b expected %b", i, ctrl, 5'b11001);
      else n_pass++;
      n_checks++;
      if (fwd !== {2'd1, 2'd0}) $display("FAIL frz_fwd_%0d: got %b expected %b", i, fwd, {2'd1, 2'd0});
      else n_pass++;
      tick();
    end
    mem_busywait = 1'b0;
    settle();
    n_checks++;
    if (ctrl !== 5'b11010) $display("FAIL frz_release_stall: got %b expected %b", ctrl, 5'b11010);
    else n_pass++;
    tick();
    settle();
    n_checks++;
    if (ctrl !== 5'b00000) $display("FAIL frz_single_stall: got %b expected %b", ctrl, 5'b00000);
    else n_pass++;
    tick();
    idle_id();
    settle();
    n_checks++;
    if (fwd !== {2'd2, 2'd3}) $display("FAIL frz_fwd_after: got %b expected %b", fwd, {2'd2, 2'd3});
    else n_pass++;
    n_checks++;
    if (stall_cnt !== (CNT_EN ? 32'd2 : 32'd0))
      $display("FAIL frz_stall_cnt: got %0d expected %0d", stall_cnt, (CNT_EN ? 2 : 0));
    else n_pass++;
  endtask

  task automatic test_redirect_freeze();
    drain();
    // add x9,x1,x2 sits in ID while a branch in EX is frozen
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
    ex_redirect  = 1'b1;
    mem_busywait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (ctrl !== 5'b11001) $display("FAIL rf_frozen_%0d: got %b expected %b", i, ctrl, 5'b11001);
      else n_pass++;
      tick();
    end
    mem_busywait = 1'b0;
    settle();
    n_checks++;
    if (ctrl !== 5'b00110) $display("FAIL rf_redirect_kept: got %b expected %b", ctrl, 5'b00110);
    else n_pass++;
    tick();
    ex_redirect = 1'b0;
    // add x10,x9,x0: x9 was flushed, so nothing forwards
    set_id(1, 5'd9, 1, 5'd0, 1, 5'd10, 1, 0);
    tick();
    idle_id();
    settle();
    n_checks++;
    if (fwd !== 4'b0000) $display("FAIL rf_flushed_fwd: got %b expected %b", fwd, 4'b0000);
    else n_pass++;
    n_checks++;
    if (flush_cnt !== (CNT_EN ? 32'd2 : 32'd0))
      $display("FAIL rf_flush_cnt: got %0d expected %0d", flush_cnt, (CNT_EN ? 2 : 0));
    else n_pass++;
  endtask

  task automatic test_x0();
    drain();
    // addi x0,x0,1
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
    tick();
    // add x1,x0,x0
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0);
    settle();
    n_checks++;
    if (ctrl !== 5'b00000) $display("FAIL x0_ctrl: got %b expected %b", ctrl, 5'b00000);
    else n_pass++;
    tick();
    // lw x0,0(x1)
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
    settle();
    n_checks++;
    if (fwd !== 4'b0000) $display("FAIL x0_fwd: got %b expected %b", fwd, 4'b0000);
    else n_pass++;
    tick();
    // add x2,x0,x0 behind lw x0: no load-use stall
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0);
    settle();
    n_checks++;
    if (ctrl !== 5'b00000) $display("FAIL x0_no_stall: got %b expected %b", ctrl, 5'b00000);
    else n_pass++;
    n_checks++;
    if (fwd !== {2'd1, 2'd0}) $display("FAIL x0_lw_base_fwd: got %b expected %b", fwd, {2'd1, 2'd0});
    else n_pass++;
    tick();
    idle_id();
    settle();
    n_checks++;
    if (fwd !== 4'b0000) $display("FAIL x0_add_fwd: got %b expected %b", fwd, 4'b0000);
    else n_pass++;
    n_checks++;
    if ({stall_cnt, flush_cnt} !== (CNT_EN ? {32'd2, 32'd2} : 64'd0))
      $display("FAIL final_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt,
               (CNT_EN ? 2 : 0), (CNT_EN ? 2 : 0));
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_id();
    ex_redirect  = 1'b0;
    mem_busywait = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_freeze();
    test_redirect_freeze();
    test_x0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
